// File: rtl/scie_pkg.sv
// scie_pkg: shared opcode, instruction and FSM state definitions for the SCIE issuer.
package scie_pkg;
   localparam int XLEN_DEF = 32;
   localparam logic [31:0] INSN_LOAD_COEF   = 32'd11;
   localparam logic [31:0] INSN_PUSH_SAMPLE = 32'd43;
   localparam logic [31:0] INSN_PUSH_READ   = 32'd59;
   typedef enum logic [1:0] {OP_LOAD_COEF, OP_PUSH_SAMPLE, OP_PUSH_READ, OP_RSVD} op_e;
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;
   function automatic logic [31:0] op_insn(input op_e op);
      return op == OP_LOAD_COEF ? INSN_LOAD_COEF : op == OP_PUSH_SAMPLE ? INSN_PUSH_SAMPLE : INSN_PUSH_READ;
   endfunction
endpackage

// File: rtl/scie_issuer.sv
// scie_issuer: issues LOAD_COEF/PUSH_SAMPLE/PUSH_READ to a SCIE unit and returns PUSH_READ results.
module scie_issuer
   import scie_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int LATENCY = 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [1:0]      req_op_i,
   input  logic [XLEN-1:0] req_rs1_i,
   input  logic [XLEN-1:0] req_rs2_i,
   output logic            scie_valid_o,
   output logic [31:0]     scie_insn_o,
   output logic [XLEN-1:0] scie_rs1_o,
   output logic [XLEN-1:0] scie_rs2_o,
   input  logic [XLEN-1:0] scie_rd_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [XLEN-1:0] rsp_data_o,
   output logic            busy_o
);
   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            scie_valid_q;
   logic [31:0]     scie_insn_q;
   logic [XLEN-1:0] scie_rs1_q, scie_rs2_q, rsp_data_q;
   logic            accept, issue, capture;
   op_e             op;
   assign op      = op_e'(req_op_i);
   assign accept  = req_valid_i && req_ready_o;
   assign issue   = accept && op != OP_RSVD;
   assign capture = state_q == ST_WAIT && cnt_q == 4'd0;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: if (accept && op == OP_PUSH_READ) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(LATENCY);
         end
         ST_WAIT: if (cnt_q == 4'd0) state_d = ST_RESP; else cnt_d = cnt_q - 4'd1;
         ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end
   always_comb begin
      req_ready_o = state_q == ST_IDLE;
      rsp_valid_o = state_q == ST_RESP;
      busy_o      = state_q != ST_IDLE || scie_valid_q;
   end
   // issue registers hold their last values while idle so the SCIE unit sees stable operands
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scie_valid_q <= 1'b0;
         scie_insn_q  <= '0;
         scie_rs1_q   <= '0;
         scie_rs2_q   <= '0;
         rsp_data_q   <= '0;
      end else begin
         scie_valid_q <= issue;
         if (issue) begin
            scie_insn_q <= op_insn(op);
            scie_rs1_q  <= req_rs1_i;
            scie_rs2_q  <= req_rs2_i;
         end
         if (capture) rsp_data_q <= scie_rd_i;
      end
   end
   assign scie_valid_o = scie_valid_q;
   assign scie_insn_o  = scie_insn_q;
   assign scie_rs1_o   = scie_rs1_q;
   assign scie_rs2_o   = scie_rs2_q;
   assign rsp_data_o   = rsp_data_q;
endmodule

// File: tb/tb_scie_issuer.sv
// tb_scie_issuer: scoreboard bench for scie_issuer at LATENCY=1 and LATENCY=3.
module tb_scie_issuer;
   typedef struct {logic [31:0] insn; logic [31:0] rs1; logic [31:0] rs2;} iss_t;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req_valid = 1'b0, rsp_ready = 1'b0;
   logic [1:0]  req_op = 2'd0;
   logic [31:0] rs1 = '0, rs2 = '0, rd = '0;
   logic        req_ready, scie_valid, rsp_valid, busy;
   logic [31:0] scie_insn, scie_rs1, scie_rs2, rsp_data;
   logic        req_valid3 = 1'b0, rsp_ready3 = 1'b0;
   logic [1:0]  req_op3 = 2'd0;
   logic [31:0] rd3 = '0;
   logic        req_ready3, scie_valid3, rsp_valid3, busy3;
   logic [31:0] scie_insn3, scie_rs13, scie_rs23, rsp_data3;
   iss_t        iss_q[$];
   logic [31:0] rsp_q[$];
   int          n_checks = 0, n_fail = 0;
   localparam logic [31:0] STEP = 32'h0001_2345;
   always #5 clk = ~clk;
   always @(posedge clk) rd3 <= rd3 + STEP;
   scie_issuer #(.XLEN(32), .LATENCY(1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_op_i(req_op), .req_rs1_i(rs1), .req_rs2_i(rs2), .scie_valid_o(scie_valid),
      .scie_insn_o(scie_insn), .scie_rs1_o(scie_rs1), .scie_rs2_o(scie_rs2), .scie_rd_i(rd),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .busy_o(busy));
   scie_issuer #(.XLEN(32), .LATENCY(3)) dut3 (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid3), .req_ready_o(req_ready3),
      .req_op_i(req_op3), .req_rs1_i(32'd0), .req_rs2_i(32'd0), .scie_valid_o(scie_valid3),
      .scie_insn_o(scie_insn3), .scie_rs1_o(scie_rs13), .scie_rs2_o(scie_rs23), .scie_rd_i(rd3),
      .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3), .rsp_data_o(rsp_data3), .busy_o(busy3));
   always @(negedge clk) if (rst_n) begin
      if (scie_valid) begin
         n_checks++;
         if (iss_q.size() == 0) begin
            n_fail++;
            $display("FAIL issue_unexpected: insn=%0d rs1=%0d, required no issue", scie_insn, scie_rs1);
         end else begin
            iss_t e;
            e = iss_q.pop_front();
            if (scie_insn !== e.insn || scie_rs1 !== e.rs1 || scie_rs2 !== e.rs2) begin
               n_fail++;
               $display("FAIL issue: insn=%0d rs1=%0d rs2=%0d, required %0d %0d %0d",
                        scie_insn, scie_rs1, scie_rs2, e.insn, e.rs1, e.rs2);
            end
         end
      end
      if (rsp_valid && rsp_ready) begin
         n_checks++;
         if (rsp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rsp_unexpected: data=%0d, required no response", rsp_data);
         end else begin
            logic [31:0] e;
            e = rsp_q.pop_front();
            if (rsp_data !== e) begin
               n_fail++;
               $display("FAIL rsp: data=%0d, required %0d", rsp_data, e);
            end
         end
      end
   end
   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      req_valid = 1'b1; req_op = op; rs1 = a; rs2 = b;
      if (op != 2'd3) iss_q.push_back('{op == 2'd0 ? 32'd11 : op == 2'd1 ? 32'd43 : 32'd59, a, b});
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask
   task automatic test_reset;
      #12;
      n_checks++;
      if ({scie_valid, rsp_valid, busy} !== 3'b000 || scie_insn !== 0 || scie_rs1 !== 0 ||
          scie_rs2 !== 0 || rsp_data !== 0) begin
         n_fail++;
         $display("FAIL reset_values: v=%b rv=%b busy=%b insn=%0d rs1=%0d rs2=%0d data=%0d, required all 0",
                  scie_valid, rsp_valid, busy, scie_insn, scie_rs1, scie_rs2, rsp_data);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (req_ready !== 1'b1 || req_ready3 !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: req_ready=%b req_ready3=%b busy=%b, required 1 1 0", req_ready, req_ready3, busy);
      end
   endtask
   task automatic test_back_to_back;
      send(2'd0, 32'd367020, 32'd0);
      n_checks++;
      if (req_ready !== 1'b1 || scie_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_first: req_ready=%b scie_valid=%b, required 1 1", req_ready, scie_valid);
      end
      send(2'd0, 32'd496472, 32'd1);
      n_checks++;
      if (req_ready !== 1'b1 || scie_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_second: req_ready=%b scie_valid=%b, required 1 1", req_ready, scie_valid);
      end
      @(posedge clk); #1;
      n_checks++;
      if (scie_valid !== 1'b0 || scie_insn !== 32'd11 || scie_rs1 !== 32'd496472 || scie_rs2 !== 32'd1) begin
         n_fail++;
         $display("FAIL b2b_hold: v=%b insn=%0d rs1=%0d rs2=%0d, required 0 11 496472 1",
                  scie_valid, scie_insn, scie_rs1, scie_rs2);
      end
   endtask
   task automatic test_push_read;
      rd = 32'd7017045;
      rsp_ready = 1'b0;
      send(2'd1, 32'd1252981, 32'd0);
      rsp_q.push_back(32'd7017045);
      send(2'd2, 32'd0, 32'd0);
      n_checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL read_wait: req_ready=%b rsp_valid=%b busy=%b, required 0 0 1", req_ready, rsp_valid, busy);
      end
      @(posedge clk); #1;
      n_checks++;
      if (rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL read_early: rsp_valid=%b one edge after accept, required 0", rsp_valid);
      end
      @(posedge clk); #1;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd7017045) begin
         n_fail++;
         $display("FAIL read_result: rsp_valid=%b data=%0d, required 1 7017045", rsp_valid, rsp_data);
      end
   endtask
   task automatic test_resp_hold;
      req_valid = 1'b1; req_op = 2'd0; rs1 = 32'd99;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== 32'd7017045 || req_ready !== 1'b0 || scie_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL resp_hold[%0d]: rv=%b data=%0d ready=%b sv=%b, required 1 7017045 0 0",
                     i, rsp_valid, rsp_data, req_ready, scie_valid);
         end
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL resp_done: rsp_valid=%b req_ready=%b, required 0 1", rsp_valid, req_ready);
      end
   endtask
   task automatic test_latency3;
      logic [31:0] exp;
      req_valid3 = 1'b1; req_op3 = 2'd2;
      @(posedge clk); #1;
      req_valid3 = 1'b0;
      exp = rd3 + 3 * STEP;
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (rsp_valid3 !== 1'b0) begin
            n_fail++;
            $display("FAIL lat3_early[%0d]: rsp_valid=%b, required 0", i, rsp_valid3);
         end
      end
      @(posedge clk); #1;
      n_checks++;
      if (rsp_valid3 !== 1'b1 || rsp_data3 !== exp || scie_insn3 !== 32'd59) begin
         n_fail++;
         $display("FAIL lat3_result: rv=%b data=%h insn=%0d, required 1 %h 59", rsp_valid3, rsp_data3, scie_insn3, exp);
      end
      rsp_ready3 = 1'b1;
      @(posedge clk); #1;
      rsp_ready3 = 1'b0;
      n_checks++;
      if (rsp_valid3 !== 1'b0 || req_ready3 !== 1'b1) begin
         n_fail++;
         $display("FAIL lat3_done: rsp_valid=%b req_ready=%b, required 0 1", rsp_valid3, req_ready3);
      end
   endtask
   task automatic test_reset_wait;
      rd = 32'd123;
      send(2'd2, 32'd5, 32'd6);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({scie_valid, rsp_valid, busy} !== 3'b000 || scie_insn !== 0 || scie_rs1 !== 0 ||
          scie_rs2 !== 0 || rsp_data !== 0) begin
         n_fail++;
         $display("FAIL reset_wait: v=%b rv=%b busy=%b insn=%0d rs1=%0d rs2=%0d data=%0d, required all 0",
                  scie_valid, rsp_valid, busy, scie_insn, scie_rs1, scie_rs2, rsp_data);
      end
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_no_late[%0d]: rsp_valid=%b req_ready=%b, required 0 1", i, rsp_valid, req_ready);
         end
      end
   endtask
   task automatic test_rsvd;
      send(2'd1, 32'h0000_1234, 32'd7);
      send(2'd3, 32'hDEAD_BEEF, 32'd0);
      n_checks++;
      if (scie_valid !== 1'b0 || scie_rs1 !== 32'h0000_1234 || scie_insn !== 32'd43 || req_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rsvd: sv=%b rs1=%h insn=%0d ready=%b busy=%b, required 0 00001234 43 1 0",
                  scie_valid, scie_rs1, scie_insn, req_ready, busy);
      end
   endtask
   initial begin
      test_reset;
      test_back_to_back;
      test_push_read;
      test_resp_hold;
      test_latency3;
      test_reset_wait;
      test_rsvd;
      @(posedge clk); #1;
      n_checks++;
      if (iss_q.size() != 0 || rsp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: issues=%0d rsps=%0d left, required 0 0", iss_q.size(), rsp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
